// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one ALU between two requesters.
// Optional ALU_ARB_ZERO_FLAG_EN adds a registered zero flag beside result.
module alu_arbiter #(
  parameter int WIDTH = 9,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OP_W-1:0]  op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OP_W-1:0]  op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_q
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OP_W-1:0]  r_alu_op;

  logic w_start;
  logic w_sel;
  logic w_exec;

  assign w_exec = (r_state == S_EXEC);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sel       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_start     = 1'b1;
          // on contention the port that did not win last time goes first
          w_sel       = (req0 && req1) ? ~r_last : req1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_result <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_start) begin
        r_alu_a  <= w_sel ? a1 : a0;
        r_alu_b  <= w_sel ? b1 : b0;
        r_alu_op <= w_sel ? op1 : op0;
        r_gnt0   <= ~w_sel;
        r_gnt1   <= w_sel;
        r_last   <= w_sel;
      end
      if (w_exec) begin
        r_result <= alu_q;
        r_done0  <= ~r_last;
        r_done1  <= r_last;
        r_gnt0   <= 1'b0;
        r_gnt1   <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero <= 1'b1;
    end else if (w_exec) begin
      r_zero <= (alu_q == '0);
    end
  end

  assign zero = r_zero;
`endif

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign busy   = w_exec;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign alu_op = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against
// a transaction-level model; the bench also plays the role of the ALU.
module tb_alu_arbiter;

  localparam int W  = 9;
  localparam int OW = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [W-1:0]  a0    = '0;
  logic [W-1:0]  b0    = '0;
  logic [W-1:0]  a1    = '0;
  logic [W-1:0]  b1    = '0;
  logic [OW-1:0] op0   = '0;
  logic [OW-1:0] op1   = '0;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [W-1:0]  result, alu_a, alu_b, alu_q;
  logic [OW-1:0] alu_op;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic          zero;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [OW-1:0] op);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return b - a;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign alu_q = alu_f(alu_a, alu_b, alu_op);

  alu_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .op0    (op0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .op1    (op1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_q  (alu_q)
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: an op granted at edge e owns the ALU
  // through edge e+1 and its result appears after edge e+1
  logic [1:0]    e_gnt  = '0;
  logic [1:0]    e_done = '0;
  logic          e_busy = 1'b0;
  logic [W-1:0]  e_res  = '0;
  logic [W-1:0]  e_a    = '0;
  logic [W-1:0]  e_b    = '0;
  logic [OW-1:0] e_op   = '0;
  logic          e_zero = 1'b1;
  int            m_last = 1;
  int            m_own  = 0;
  int            m_w    = 0;
  logic [W-1:0]  m_pend = '0;
  logic [W-1:0]  pa [2];
  logic [W-1:0]  pb [2];
  logic [OW-1:0] po [2];
  logic          pr [2];

  always @(posedge clk) begin
    if (reset) begin
      e_gnt  = '0;
      e_done = '0;
      e_busy = 1'b0;
      e_res  = '0;
      e_a    = '0;
      e_b    = '0;
      e_op   = '0;
      e_zero = 1'b1;
      m_last = 1;
    end else begin
      pa[0] = a0; pb[0] = b0; po[0] = op0; pr[0] = req0;
      pa[1] = a1; pb[1] = b1; po[1] = op1; pr[1] = req1;
      e_done = '0;
      if (e_busy) begin
        e_res         = m_pend;
        e_zero        = (m_pend == '0);
        e_done[m_own] = 1'b1;
        e_gnt         = '0;
        e_busy        = 1'b0;
      end else if (pr[0] || pr[1]) begin
        if (pr[0] && pr[1]) m_w = 1 - m_last;
        else                m_w = pr[1] ? 1 : 0;
        m_last       = m_w;
        m_own        = m_w;
        e_a          = pa[m_w];
        e_b          = pb[m_w];
        e_op         = po[m_w];
        m_pend       = alu_f(pa[m_w], pb[m_w], po[m_w]);
        e_gnt        = '0;
        e_gnt[m_w]   = 1'b1;
        e_busy       = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("gnt0",   gnt0,   e_gnt[0]);
    check("gnt1",   gnt1,   e_gnt[1]);
    check("done0",  done0,  e_done[0]);
    check("done1",  done1,  e_done[1]);
    check("busy",   busy,   e_busy);
    check("result", result, e_res);
    check("alu_a",  alu_a,  e_a);
    check("alu_b",  alu_b,  e_b);
    check("alu_op", alu_op, e_op);
`ifdef ALU_ARB_ZERO_FLAG_EN
    check("zero",   zero,   e_zero);
`endif
  end

  // one op on one port; chg >= 0 rewrites a in the grant cycle
  task automatic do_op(input int p, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [OW-1:0] op,
                       input int chg, output logic [W-1:0] r);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (p == 0) begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? gnt0 : gnt1;
    end
    check("gnt_seen", seen, 1);
    check("gnt_other", (p == 0) ? gnt1 : gnt0, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    if (chg >= 0) begin
      if (p == 0) a0 = W'(chg);
      else        a1 = W'(chg);
    end
    @(negedge clk);
    check("done_own", (p == 0) ? done0 : done1, 1);
    check("done_other", (p == 0) ? done1 : done0, 0);
    r = result;
  endtask

  int            gq[$];
  logic [W-1:0]  rq[$];
  logic [W-1:0]  r;
  logic          seen;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    reset = 1'b0;

    do_op(0, 9'd100, 9'd50, 3'b001, -1, r);
    check("add_150", r, 150);
    do_op(1, 9'd5, 9'd10, 3'b010, -1, r);
    check("sub_wrap", r, 9'h1FB);
    do_op(1, 9'd300, 9'd300, 3'b001, -1, r);
    check("add_wrap", r, 88);

    @(negedge clk); #2 reset = 1'b1;
    a0 = 9'h0F0; b0 = 9'h0FF; op0 = 3'b100;
    a1 = 9'h0F0; b1 = 9'h00F; op1 = 3'b101;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (done0 || done1) rq.push_back(result);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("fair_ngnt", 32'(gq.size() >= 4), 1);
    check("fair_nres", 32'(rq.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) check("fair_order", gq[i], i % 2);
      if (i < rq.size()) check("fair_res", rq[i], (i % 2) ? 9'h0FF : 9'h0F0);
    end
    for (int i = 1; i < gq.size(); i++)
      check("no_repeat", 32'(gq[i] != gq[i-1]), 1);
    repeat (2) @(negedge clk);

    do_op(0, 9'd7, 9'd0, 3'b000, 9, r);
    check("late_a", r, 7);

    @(negedge clk);
    req0 = 1'b1; a0 = 9'd3; b0 = 9'd4; op0 = 3'b001;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = gnt0;
    end
    check("abort_gnt", seen, 1);
    #2 reset = 1'b1; req0 = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_res", result, 0);
    check("abort_gnt0", gnt0, 0);
    @(negedge clk);
    check("abort_done0", done0, 0);
    check("abort_done1", done1, 0);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = gnt0 | gnt1;
    end
    check("post_rst_gnt", seen, 1);
    check("post_rst_p0", gnt0, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

`ifdef ALU_ARB_ZERO_FLAG_EN
    do_op(0, 9'h155, 9'h155, 3'b110, -1, r);
    check("zf_res", r, 0);
    check("zf_set", zero, 1);
    do_op(1, 9'd1, 9'd0, 3'b001, -1, r);
    check("zf_res1", r, 1);
    check("zf_clr", zero, 0);
`endif

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (req0 && gnt0 && $urandom_range(3) != 0) begin
        req0 = 1'b0;
      end else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1;
        a0 = W'($urandom_range(511)); b0 = W'($urandom_range(511));
        op0 = OW'($urandom_range(7));
      end
      if (req1 && gnt1 && $urandom_range(3) != 0) begin
        req1 = 1'b0;
      end else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1;
        a1 = W'($urandom_range(511)); b1 = W'($urandom_range(511));
        op1 = OW'($urandom_range(7));
      end
      if ($urandom_range(7) == 0) a0 = W'($urandom_range(511));
      if ($urandom_range(7) == 0) b1 = W'($urandom_range(511));
      if ($urandom_range(120) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 9-bit ALU between two requesters (port 0, port 1) with round-robin arbitration and a req/gnt/done handshake.
- Latches the winning requester's operands and opcode, drives the ALU inputs from registers, then captures the ALU output into a result register and pulses done to the owner.
- Sits between the requesting control logic and the ALU. It is a pure sequencer: it adds no arithmetic of its own.

Parameters:
- WIDTH, 9, data width of operands, ALU inputs/output and result.
- OP_W, 3, opcode width (8 ops: pass a, add, a-b, b-a, and, or, xor, xnor).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  port 0 request; held high until gnt0 is seen
- a0, b0  input  WIDTH  port 0 operands
- op0  input  OP_W  port 0 opcode
- req1  input  1  port 1 request
- a1, b1  input  WIDTH  port 1 operands
- op1  input  OP_W  port 1 opcode
- gnt0, gnt1  output  1  one-cycle grant pulse; operands were sampled on the edge that raised it
- done0, done1  output  1  one-cycle completion pulse; result valid while high
- result  output  WIDTH  registered ALU result of the last completed operation
- busy  output  1  high in the EXEC state
- alu_a, alu_b  output  WIDTH  registered operands to the ALU
- alu_op  output  OP_W  registered opcode to the ALU
- alu_q  input  WIDTH  combinational ALU output

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - state=IDLE; gnt0/1=0; done0/1=0; busy=0.
  - result=0; alu_a/alu_b/alu_op=0.
  - last=1, so port 0 wins the first contention.
- FSM with two states, IDLE and EXEC.
- IDLE:
  - With no req, stay in IDLE; alu_a/alu_b/alu_op hold their values.
  - If exactly one req is high, select it. If both are high, select the port != last.
  - On the clock edge:
    - alu_a/alu_b/alu_op <= selected a/b/op;
    - gnt_sel <= 1;
    - last <= sel;
    - state <= EXEC.
- EXEC (exactly one cycle):
  - busy=1; gnt pulse is high during this cycle; the ALU settles on the registered inputs.
  - On the clock edge:
    - result <= alu_q;
    - done_sel <= 1 (one cycle);
    - gnt <= 0;
    - state <= IDLE.
  - req inputs are ignored while in EXEC.
- Latency and throughput:
  - req sampled at edge N -> gnt high during N..N+1 -> result and done valid during N+1..N+2.
  - Back-to-back throughput is one op per 2 cycles.
- Requester rules:
  - A requester must drop req in the cycle gnt is high (the done cycle is also acceptable). A req still high in the done cycle is treated as a new request.
  - Operand changes after the grant edge have no effect on the current op.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1 and neither port is starved.
- result holds its value until the next EXEC edge; done is the only validity qualifier.
- Arithmetic is entirely the ALU's. Results wrap modulo 2^WIDTH with no carry or borrow; this block neither inspects nor alters them.
- Reset during EXEC aborts the op: no done pulse, result=0, last=1.

Optional Feature:
- Macro ALU_ARB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit), registered alongside result: zero <= (alu_q == 0) on the EXEC edge.
  - Reset value 1, consistent with result=0. Holds its value with result.
- Undefined: zero port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset, then port 0 only with a0=100, b0=50, op0=001 -> gnt0 for 1 cycle; one cycle later done0=1 and result=150; gnt1 and done1 stay 0.
- Port 1 only with a1=5, b1=10, op1=010 -> done1=1 and result=9'h1FB (wrap); port 1 with a1=300, b1=300, op1=001 -> result=88.
- req0 and req1 both held high from reset (port 0: 9'h0F0 & 9'h0FF, op 100; port 1: 9'h0F0 | 9'h00F, op 101):
  - grant order is 0,1,0,1;
  - results alternate 9'h0F0 / 9'h0FF;
  - no port receives two consecutive grants.
- Change a0 from 7 to 9 in the gnt0 cycle (op0=000) -> result=7.
- Assert reset during EXEC -> no done pulse, result=0, busy=0; the next contention grants port 0.
- ALU_ARB_ZERO_FLAG_EN defined, op 110 with a=b=9'h155 -> result=0 and zero=1; a following op 001 with a=1, b=0 -> zero=0.
